axis_stream_checker: RTL and testbench

//  AXI4-Stream sink placed directly downstream of axis_bram's M_AXIS port. It consumes one read burst,

---
 rtl/axis_stream_checker.sv | 178 +++++++++++++++++
 tb/tb_axis_stream_checker.sv | 289 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/axis_stream_checker.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : axis_stream_checker                                          |
// | Description : AXI4-Stream sink that checks one burst against an arithmetic |
// |               sequence and tlast placement, then reports pass/fail.        |
// |               Optional tready throttling via AXIS_CHK_THROTTLE_EN.         |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module axis_stream_checker #(
    parameter int         C_AXIS_BRAM_DATA_WIDTH = 8,
    parameter int         C_AXIS_BRAM_ADDR_WIDTH = 7,
    parameter int         C_CHK_CNT_WIDTH        = 16,
    parameter logic [7:0] C_THROTTLE_PATTERN     = 8'hB5
) (
    input  logic                                  clk,
    input  logic                                  reset_n,
    input  logic                                  ctrl_start,
    input  logic [C_AXIS_BRAM_ADDR_WIDTH-1:0]     ctrl_length,
    input  logic [C_AXIS_BRAM_DATA_WIDTH-1:0]     ctrl_first_data,
    input  logic [C_AXIS_BRAM_DATA_WIDTH-1:0]     ctrl_data_step,
    input  logic                                  s_axis_tvalid,
    output logic                                  s_axis_tready,
    input  logic [C_AXIS_BRAM_DATA_WIDTH-1:0]     s_axis_tdata,
    input  logic [C_AXIS_BRAM_DATA_WIDTH/8-1:0]   s_axis_tstrb,
    input  logic                                  s_axis_tlast,
    output logic                                  sts_busy,
    output logic                                  sts_done,
    output logic                                  sts_pass,
    output logic [C_CHK_CNT_WIDTH-1:0]            sts_beat_cnt,
    output logic [C_CHK_CNT_WIDTH-1:0]            sts_data_err_cnt,
    output logic [C_CHK_CNT_WIDTH-1:0]            sts_last_err_cnt,
    output logic [C_AXIS_BRAM_ADDR_WIDTH-1:0]     sts_first_err_idx
);

    localparam logic [C_AXIS_BRAM_ADDR_WIDTH-1:0]   c_idx_none = '1;
    localparam logic [C_AXIS_BRAM_ADDR_WIDTH-1:0]   c_idx_one  = {{(C_AXIS_BRAM_ADDR_WIDTH-1){1'b0}}, 1'b1};
    localparam logic [C_CHK_CNT_WIDTH-1:0]          c_cnt_one  = {{(C_CHK_CNT_WIDTH-1){1'b0}}, 1'b1};
    localparam logic [C_CHK_CNT_WIDTH-1:0]          c_cnt_max  = '1;
    localparam logic [C_AXIS_BRAM_DATA_WIDTH/8-1:0] c_strb_all = '1;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t                              r_state;
    state_t                              w_state_next;
    logic [C_AXIS_BRAM_ADDR_WIDTH-1:0]   r_len;
    logic [C_AXIS_BRAM_ADDR_WIDTH-1:0]   r_idx;
    logic [C_AXIS_BRAM_DATA_WIDTH-1:0]   r_exp;
    logic [C_AXIS_BRAM_DATA_WIDTH-1:0]   r_step;
    logic [C_CHK_CNT_WIDTH-1:0]          r_beat_cnt;
    logic [C_CHK_CNT_WIDTH-1:0]          r_data_err_cnt;
    logic [C_CHK_CNT_WIDTH-1:0]          r_last_err_cnt;
    logic [C_AXIS_BRAM_ADDR_WIDTH-1:0]   r_first_err_idx;
    logic                                r_done;
    logic                                r_pass;
    logic                                w_tready;
    logic                                w_accept;
    logic                                w_start;
    logic                                w_is_last;
    logic                                w_data_err;
    logic                                w_last_err;
    logic                                w_busy;

`ifdef AXIS_CHK_THROTTLE_EN
    logic [7:0] r_pattern;

    // Pattern rotates every RUN cycle, independent of whether a beat was taken.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_pattern <= 8'h00;
        end else if (w_start) begin
            r_pattern <= C_THROTTLE_PATTERN;
        end else if (r_state == S_RUN) begin
            r_pattern <= {r_pattern[0], r_pattern[7:1]};
        end
    end

    assign w_tready = (r_state == S_RUN) && r_pattern[0];
`else
    logic w_unused_pattern;
    assign w_unused_pattern = ^C_THROTTLE_PATTERN;
    assign w_tready         = (r_state == S_RUN);
`endif

    assign w_start    = ctrl_start && (r_state == S_IDLE);
    assign w_accept   = s_axis_tvalid && w_tready;
    assign w_is_last  = (r_idx == (r_len - c_idx_one));
    assign w_data_err = (s_axis_tdata != r_exp) || (s_axis_tstrb != c_strb_all);
    assign w_last_err = (s_axis_tlast != w_is_last);

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        w_busy       = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (ctrl_start) begin
                    w_state_next = (ctrl_length != '0) ? S_RUN : S_DONE;
                end
            end
            S_RUN: begin
                w_busy = 1'b1;
                // An early tlast is only flagged; the burst ends on the beat count.
                if (w_accept && w_is_last) begin
                    w_state_next = S_DONE;
                end
            end
            S_DONE:  w_state_next = S_IDLE;
            default: w_state_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_len           <= '0;
            r_idx           <= '0;
            r_exp           <= '0;
            r_step          <= '0;
            r_beat_cnt      <= '0;
            r_data_err_cnt  <= '0;
            r_last_err_cnt  <= '0;
            r_first_err_idx <= c_idx_none;
            r_done          <= 1'b0;
            r_pass          <= 1'b0;
        end else begin
            r_done <= (r_state == S_DONE);
            if (r_state == S_DONE) begin
                r_pass <= (r_data_err_cnt == '0) && (r_last_err_cnt == '0);
            end
            if (w_start) begin
                r_len           <= ctrl_length;
                r_idx           <= '0;
                r_exp           <= ctrl_first_data;
                r_step          <= ctrl_data_step;
                r_beat_cnt      <= '0;
                r_data_err_cnt  <= '0;
                r_last_err_cnt  <= '0;
                r_first_err_idx <= c_idx_none;
                r_pass          <= 1'b0;
            end else if (w_accept) begin
                r_idx      <= r_idx + c_idx_one;
                r_exp      <= r_exp + r_step;
                r_beat_cnt <= r_beat_cnt + c_cnt_one;
                if (w_data_err && (r_data_err_cnt != c_cnt_max)) begin
                    r_data_err_cnt <= r_data_err_cnt + c_cnt_one;
                end
                if (w_last_err && (r_last_err_cnt != c_cnt_max)) begin
                    r_last_err_cnt <= r_last_err_cnt + c_cnt_one;
                end
                // Maximum burst is one short of all-ones, so all-ones never names a real beat.
                if ((w_data_err || w_last_err) && (r_first_err_idx == c_idx_none)) begin
                    r_first_err_idx <= r_idx;
                end
            end
        end
    end

    assign s_axis_tready     = w_tready;
    assign sts_busy          = w_busy;
    assign sts_done          = r_done;
    assign sts_pass          = r_pass;
    assign sts_beat_cnt      = r_beat_cnt;
    assign sts_data_err_cnt  = r_data_err_cnt;
    assign sts_last_err_cnt  = r_last_err_cnt;
    assign sts_first_err_idx = r_first_err_idx;

endmodule
`default_nettype wire

// File: tb/tb_axis_stream_checker.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : tb_axis_stream_checker                                       |
// | Description : Scoreboard bench for axis_stream_checker: directed bursts    |
// |               plus random bursts against a closed-form reference model.    |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module tb_axis_stream_checker;

    localparam int DW = 8;
    localparam int AW = 7;
    localparam int CW = 16;
    localparam int SW = DW / 8;

    logic          clk = 1'b0;
    logic          reset_n = 1'b0;
    logic          ctrl_start = 1'b0;
    logic [AW-1:0] ctrl_length = '0;
    logic [DW-1:0] ctrl_first_data = '0;
    logic [DW-1:0] ctrl_data_step = '0;
    logic          s_axis_tvalid = 1'b0;
    logic          s_axis_tready;
    logic [DW-1:0] s_axis_tdata = '0;
    logic [SW-1:0] s_axis_tstrb = '1;
    logic          s_axis_tlast = 1'b0;
    logic          sts_busy;
    logic          sts_done;
    logic          sts_pass;
    logic [CW-1:0] sts_beat_cnt;
    logic [CW-1:0] sts_data_err_cnt;
    logic [CW-1:0] sts_last_err_cnt;
    logic [AW-1:0] sts_first_err_idx;

    axis_stream_checker #(
        .C_AXIS_BRAM_DATA_WIDTH (DW),
        .C_AXIS_BRAM_ADDR_WIDTH (AW),
        .C_CHK_CNT_WIDTH        (CW),
        .C_THROTTLE_PATTERN     (8'hB5)
    ) dut (
        .clk               (clk),
        .reset_n           (reset_n),
        .ctrl_start        (ctrl_start),
        .ctrl_length       (ctrl_length),
        .ctrl_first_data   (ctrl_first_data),
        .ctrl_data_step    (ctrl_data_step),
        .s_axis_tvalid     (s_axis_tvalid),
        .s_axis_tready     (s_axis_tready),
        .s_axis_tdata      (s_axis_tdata),
        .s_axis_tstrb      (s_axis_tstrb),
        .s_axis_tlast      (s_axis_tlast),
        .sts_busy          (sts_busy),
        .sts_done          (sts_done),
        .sts_pass          (sts_pass),
        .sts_beat_cnt      (sts_beat_cnt),
        .sts_data_err_cnt  (sts_data_err_cnt),
        .sts_last_err_cnt  (sts_last_err_cnt),
        .sts_first_err_idx (sts_first_err_idx)
    );

    always #5 clk = ~clk;

    typedef struct {
        int unsigned beats;
        int unsigned derr;
        int unsigned lerr;
        int unsigned idx;
        bit          pass;
    } exp_t;

    exp_t            sb[$];
    logic [DW-1:0]   bd[$];
    logic [SW-1:0]   bs[$];
    logic            bl[$];
    int              n_cmp = 0;
    int              n_bad = 0;
    int              max_gap = 0;

    task automatic check(input string name, input longint unsigned act, input longint unsigned req);
        n_cmp++;
        if (act !== req) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, req);
        end
    endtask

    // Reference: expected beat i is first + i*step, tlast belongs only on beat len-1.
    function automatic exp_t model(input int len, input int first, input int step);
        exp_t r;
        r.beats = len; r.derr = 0; r.lerr = 0; r.idx = (1 << AW) - 1;
        for (int i = 0; i < len; i++) begin
            int  e;
            bit  de, le;
            e  = (first + i * step) % (1 << DW);
            de = (int'(bd[i]) != e) || (bs[i] != {SW{1'b1}});
            le = (bl[i] != (i == len - 1));
            if (de) r.derr++;
            if (le) r.lerr++;
            if ((de || le) && r.idx == (1 << AW) - 1) r.idx = i;
        end
        r.pass = (r.derr == 0) && (r.lerr == 0);
        return r;
    endfunction

    // Monitor: every done pulse is matched against the oldest expected result.
    always @(negedge clk) begin
        if (reset_n && sts_done) begin
            if (sb.size() == 0) begin
                check("spurious_done", sts_done, 0);
            end else begin
                exp_t e;
                e = sb.pop_front();
                check("beat_cnt",      sts_beat_cnt,      e.beats);
                check("data_err_cnt",  sts_data_err_cnt,  e.derr);
                check("last_err_cnt",  sts_last_err_cnt,  e.lerr);
                check("first_err_idx", sts_first_err_idx, e.idx);
                check("pass",          sts_pass,          e.pass);
            end
        end
    end

    task automatic pulse_start(input int len, input int first, input int step);
        @(posedge clk); #1;
        ctrl_length     = AW'(len);
        ctrl_first_data = DW'(first);
        ctrl_data_step  = DW'(step);
        ctrl_start      = 1'b1;
        @(posedge clk); #1;
        ctrl_start      = 1'b0;
    endtask

    task automatic drive_beat(input logic [DW-1:0] d, input logic [SW-1:0] s, input logic l);
        int n = 0;
        s_axis_tvalid = 1'b1;
        s_axis_tdata  = d;
        s_axis_tstrb  = s;
        s_axis_tlast  = l;
        @(negedge clk);
        while (!s_axis_tready && n < 64) begin
            @(negedge clk);
            n++;
        end
        if (!s_axis_tready) check("tready_timeout", s_axis_tready, 1);
        @(posedge clk); #1;
        s_axis_tvalid = 1'b0;
    endtask

    task automatic drive_beats(input int count);
        for (int i = 0; i < count; i++) begin
            int gap = (max_gap > 0) ? $urandom_range(0, max_gap) : 0;
            if (gap > 0) begin
                s_axis_tvalid = 1'b0;
                repeat (gap) begin @(posedge clk); #1; end
            end
            drive_beat(bd[i], bs[i], bl[i]);
        end
    endtask

    task automatic wait_drain();
        int n = 0;
        while (sb.size() != 0 && n < 40) begin
            @(negedge clk);
            n++;
        end
        if (sb.size() != 0) begin
            check("done_timeout", sb.size(), 0);
            sb.delete();
        end
        @(posedge clk); #1;
    endtask

    task automatic run_burst(input int len, input int first, input int step);
        sb.push_back(model(len, first, step));
        pulse_start(len, first, step);
        drive_beats(len);
        wait_drain();
    endtask

    task automatic load4(input int d0, input int d1, input int d2, input int d3,
                         input logic [3:0] last);
        bd = '{DW'(d0), DW'(d1), DW'(d2), DW'(d3)};
        bs = '{'1, '1, '1, '1};
        bl = '{last[0], last[1], last[2], last[3]};
    endtask

`ifdef AXIS_CHK_THROTTLE_EN
    logic rq[$];
    bit   rec = 1'b0;
    always @(negedge clk) if (rec && sts_busy) rq.push_back(s_axis_tready);
`endif

    initial begin
        repeat (3) @(posedge clk);
        #1;
        @(negedge clk);
        check("rst_tready", s_axis_tready, 0);
        check("rst_busy",   sts_busy, 0);
        check("rst_done",   sts_done, 0);
        check("rst_pass",   sts_pass, 0);
        check("rst_beats",  sts_beat_cnt, 0);
        check("rst_derr",   sts_data_err_cnt, 0);
        check("rst_lerr",   sts_last_err_cnt, 0);
        check("rst_idx",    sts_first_err_idx, {AW{1'b1}});
        @(posedge clk); #1;
        reset_n = 1'b1;

        load4('h40, 'h50, 'h60, 'h70, 4'b1000);
        run_burst(4, 'h40, 'h10);
        load4('h01, 'h11, 'h99, 'h31, 4'b1000);
        run_burst(4, 'h01, 'h10);
        load4('h40, 'h50, 'h60, 'h70, 4'b0010);
        run_burst(4, 'h40, 'h10);

        // Zero-length burst: done appears two cycles after the start edge.
        bd.delete(); bs.delete(); bl.delete();
        sb.push_back(model(0, 0, 0));
        pulse_start(0, 'h12, 'h34);
        @(negedge clk);
        check("len0_done_early", sts_done, 0);
        check("len0_tready_a",   s_axis_tready, 0);
        @(negedge clk);
        check("len0_done",       sts_done, 1);
        check("len0_tready_b",   s_axis_tready, 0);
        wait_drain();

        // Reset halfway through a burst abandons it without a done pulse.
        load4('h40, 'h50, 'h60, 'h70, 4'b1000);
        pulse_start(4, 'h40, 'h10);
        drive_beats(2);
        reset_n = 1'b0;
        @(posedge clk); #1;
        reset_n = 1'b1;
        @(negedge clk);
        check("mid_rst_busy",  sts_busy, 0);
        check("mid_rst_beats", sts_beat_cnt, 0);
        check("mid_rst_derr",  sts_data_err_cnt, 0);
        check("mid_rst_idx",   sts_first_err_idx, {AW{1'b1}});
        repeat (4) @(negedge clk);
        @(posedge clk); #1;
        run_burst(4, 'h40, 'h10);

        max_gap = 2;
        for (int b = 0; b < 40; b++) begin
            int len   = $urandom_range(0, 10);
            int first = $urandom_range(0, 255);
            int step  = $urandom_range(0, 255);
            bd.delete(); bs.delete(); bl.delete();
            for (int i = 0; i < len; i++) begin
                logic [DW-1:0] d;
                logic [SW-1:0] s;
                logic          l;
                int            m = $urandom_range(0, 11);
                d = DW'(first + i * step);
                s = '1;
                l = (i == len - 1);
                if (m == 0) d = d ^ DW'($urandom_range(1, 255));
                if (m == 1) s = ~s;
                if (m == 2) l = ~l;
                bd.push_back(d); bs.push_back(s); bl.push_back(l);
            end
            run_burst(len, first, step);
        end
        max_gap = 0;

`ifdef AXIS_CHK_THROTTLE_EN
        begin
            logic exp_r[6];
            exp_r = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1};
            load4('h40, 'h50, 'h60, 'h70, 4'b1000);
            rq.delete();
            rec = 1'b1;
            run_burst(4, 'h40, 'h10);
            rec = 1'b0;
            check("thr_run_cycles", rq.size(), 6);
            for (int i = 0; i < 6 && i < rq.size(); i++) check("thr_tready", rq[i], exp_r[i]);
        end
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL global_timeout: got running expected finished");
        $fatal(1, "timeout");
    end

endmodule
`default_nettype wire
